// File: rtl/axis_out_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_out_packer_if
//  Brief    : Input word stream plus output beat stream of the AXI-Stream packer.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_out_packer_if #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 256,
    parameter int W_BPT        = 8
);
    logic                      s_valid;
    logic                      s_ready;
    logic [S_DATA_WIDTH-1:0]   s_data;
    logic                      s_last;
    logic [W_BPT-1:0]          s_user;
    logic                      m_valid;
    logic                      m_ready;
    logic [M_DATA_WIDTH-1:0]   m_data;
    logic [M_DATA_WIDTH/8-1:0] m_keep;
    logic                      m_last;
    logic [W_BPT-1:0]          m_user;

    // slave: the packer itself; master: the environment feeding and draining it
    modport slave (
        input  s_valid, s_data, s_last, s_user, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last, m_user
    );

    modport master (
        output s_valid, s_data, s_last, s_user, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last, m_user
    );
endinterface
`default_nettype wire

// File: rtl/axis_out_packer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_out_packer
//  Brief    : Packs RATIO row words into one output beat with byte keep and
//             flushes a partial beat on s_last. Optional macro
//             AXIS_OUT_PACKER_ZERO_FILL_EN zeroes the unfilled lanes.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_out_packer #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 256,
    parameter int W_BPT        = 8
) (
    input  wire logic          aclk,
    input  wire logic          areset,
    axis_out_packer_if.slave   axis
);

    localparam int RATIO        = M_DATA_WIDTH / S_DATA_WIDTH;
    localparam int c_LANE_BYTES = S_DATA_WIDTH / 8;
    localparam int c_CNT_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_SLOT = c_CNT_W'(RATIO - 1);

    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_m_valid;
    logic [M_DATA_WIDTH-1:0]   r_m_data;
    logic [M_DATA_WIDTH/8-1:0] r_m_keep;
    logic                      r_m_last;
    logic [W_BPT-1:0]          r_m_user;

    logic                      w_s_ready;
    logic                      w_accept;
    logic                      w_complete;
    logic [M_DATA_WIDTH-1:0]   w_data_nxt;
    logic [M_DATA_WIDTH/8-1:0] w_keep_nxt;

    assign w_s_ready  = !r_m_valid || axis.m_ready;
    assign w_accept   = axis.s_valid && w_s_ready;
    assign w_complete = w_accept && ((r_cnt == c_LAST_SLOT) || axis.s_last);

    always_comb begin
        w_data_nxt = r_m_data;
        w_keep_nxt = r_m_keep;
        if (r_cnt == '0) begin
            w_keep_nxt = '0;
`ifdef AXIS_OUT_PACKER_ZERO_FILL_EN
            w_data_nxt = '0;
`else
            // unfilled lanes keep the previous beat's data; m_keep marks validity
`endif
        end
        for (int i = 0; i < RATIO; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_data_nxt[i*S_DATA_WIDTH +: S_DATA_WIDTH] = axis.s_data;
                w_keep_nxt[i*c_LANE_BYTES +: c_LANE_BYTES] = '1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_user  <= '0;
        end else begin
            if (w_accept) begin
                r_m_data <= w_data_nxt;
                r_m_keep <= w_keep_nxt;
                if (r_cnt == '0) begin
                    r_m_user <= axis.s_user;
                end
                // an accept implies any pending beat drains this same cycle
                if (w_complete) begin
                    r_m_valid <= 1'b1;
                    r_m_last  <= axis.s_last;
                    r_cnt     <= '0;
                end else begin
                    r_m_valid <= 1'b0;
                    r_cnt     <= r_cnt + 1'b1;
                end
            end else if (r_m_valid && axis.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign axis.s_ready = w_s_ready;
    assign axis.m_valid = r_m_valid;
    assign axis.m_data  = r_m_data;
    assign axis.m_keep  = r_m_keep;
    assign axis.m_last  = r_m_last;
    assign axis.m_user  = r_m_user;

endmodule
`default_nettype wire
